// File: rtl/wish_pkg.sv
// Shared definitions for the wish_* stream blocks (pack/unpack).
package wish_pkg;

  localparam int TGC_FIRST = 0;
  localparam int TGC_LAST  = 1;

  // Lane-count width: enough to hold NUM_PACK itself, not just NUM_PACK-1.
  function automatic int cnt_width(input int num_pack);
    return $clog2(num_pack) + 1;
  endfunction

endpackage

// File: rtl/wish_pack_if.sv
// Narrow Wishbone-style slave stream in, wide master stream out, for wish_pack.
interface wish_pack_if #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_PACK   = 4,
  parameter int TGC_WIDTH  = 2
);
  import wish_pkg::*;

  localparam int CNT_W = cnt_width(NUM_PACK);

  logic                           s_stb_i;
  logic                           s_cyc_i;
  logic [DATA_WIDTH-1:0]          s_dat_i;
  logic [TGC_WIDTH-1:0]           s_tgc_i;
  logic                           s_ack_o;
  logic                           s_stall_o;
  logic                           d_stb_o;
  logic                           d_cyc_o;
  logic [NUM_PACK*DATA_WIDTH-1:0] d_dat_o;
  logic [TGC_WIDTH-1:0]           d_tgc_o;
  logic [CNT_W-1:0]               d_cnt_o;
  logic                           d_ack_i;

  // Packer side: consumes the narrow stream, produces the wide stream.
  modport slave (
    input  s_stb_i, s_cyc_i, s_dat_i, s_tgc_i, d_ack_i,
    output s_ack_o, s_stall_o, d_stb_o, d_cyc_o, d_dat_o, d_tgc_o, d_cnt_o
  );

  // Environment side: drives the narrow stream and accepts wide words.
  modport master (
    output s_stb_i, s_cyc_i, s_dat_i, s_tgc_i, d_ack_i,
    input  s_ack_o, s_stall_o, d_stb_o, d_cyc_o, d_dat_o, d_tgc_o, d_cnt_o
  );

endinterface

// File: rtl/wish_pack.sv
// Packs NUM_PACK narrow stream words into one wide word; a packet ending
// mid-word emits a zero-padded partial word with its valid-lane count.
module wish_pack
  import wish_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int NUM_PACK      = 4,
  parameter int TGC_WIDTH     = 2,
  parameter bit LITTLE_ENDIAN = 1'b0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  wish_pack_if.slave  bus
);

  localparam int LANE_W = $clog2(NUM_PACK);
  localparam int CNT_W  = cnt_width(NUM_PACK);
  localparam int WIDE_W = NUM_PACK * DATA_WIDTH;

  function automatic logic [LANE_W-1:0] lane_index(input logic [LANE_W-1:0] cnt);
    if (LITTLE_ENDIAN)
      return cnt;
    else
      return LANE_W'(NUM_PACK - 1) - cnt;
  endfunction

  logic [WIDE_W-1:0]    acc_p0;
  logic [LANE_W-1:0]    lane_p0;
  logic                 first_p0;

  logic                 vld_p1;
  logic [WIDE_W-1:0]    dat_p1;
  logic [TGC_WIDTH-1:0] tgc_p1;
  logic [CNT_W-1:0]     cnt_p1;

  logic                 completing;
  logic                 ack;
  logic                 beat;
  logic [LANE_W-1:0]    idx;
  logic [WIDE_W-1:0]    merged;
  logic [TGC_WIDTH-1:0] tgc_next;

  assign completing = (lane_p0 == LANE_W'(NUM_PACK - 1)) | bus.s_tgc_i[TGC_LAST];
  // A completing beat may only proceed once the output register is free
  // (or being freed this very cycle).
  assign ack  = bus.s_stb_i & bus.s_cyc_i & ~(completing & vld_p1 & ~bus.d_ack_i);
  assign beat = bus.s_stb_i & bus.s_cyc_i & ack;
  assign idx  = lane_index(lane_p0);

  always_comb begin
    merged = acc_p0;
    for (int i = 0; i < NUM_PACK; i++) begin
      if (LANE_W'(i) == idx)
        merged[i*DATA_WIDTH +: DATA_WIDTH] = bus.s_dat_i;
    end
  end

  // Lane 0 supplies the first tag; when it is also the completing lane the
  // latched copy is not yet valid, so take it straight from the input.
  always_comb begin
    tgc_next            = bus.s_tgc_i;
    tgc_next[TGC_FIRST] = (lane_p0 == '0) ? bus.s_tgc_i[TGC_FIRST] : first_p0;
    tgc_next[TGC_LAST]  = bus.s_tgc_i[TGC_LAST];
  end

  // ---- accumulate (p0) -> output register (p1) ----
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_p0   <= '0;
      lane_p0  <= '0;
      first_p0 <= 1'b0;
      vld_p1   <= 1'b0;
      dat_p1   <= '0;
      tgc_p1   <= '0;
      cnt_p1   <= '0;
    end else begin
      if (vld_p1 && bus.d_ack_i)
        vld_p1 <= 1'b0;
      if (beat) begin
        if (completing) begin
          dat_p1  <= merged;
          tgc_p1  <= tgc_next;
          cnt_p1  <= CNT_W'(lane_p0) + CNT_W'(1);
          vld_p1  <= 1'b1;
          acc_p0  <= '0;
          lane_p0 <= '0;
        end else begin
          acc_p0  <= merged;
          lane_p0 <= lane_p0 + LANE_W'(1);
          if (lane_p0 == '0)
            first_p0 <= bus.s_tgc_i[TGC_FIRST];
        end
      end
    end
  end

  assign bus.s_ack_o   = ack;
  assign bus.s_stall_o = bus.s_cyc_i & bus.s_stb_i & ~ack;
  assign bus.d_stb_o   = vld_p1;
  assign bus.d_cyc_o   = vld_p1;
  assign bus.d_dat_o   = dat_p1;
  assign bus.d_tgc_o   = tgc_p1;
  assign bus.d_cnt_o   = cnt_p1;

endmodule

// File: tb/tb_wish_pack.sv
// Directed bench for wish_pack: big- and little-endian instances share stimulus.
module tb_wish_pack;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wish_pack_if #(.DATA_WIDTH(8), .NUM_PACK(4), .TGC_WIDTH(2)) bus0 ();
  wish_pack_if #(.DATA_WIDTH(8), .NUM_PACK(4), .TGC_WIDTH(2)) bus1 ();

  wish_pack #(.DATA_WIDTH(8), .NUM_PACK(4), .TGC_WIDTH(2), .LITTLE_ENDIAN(1'b0))
    dut (.clk_i(clk), .rst_i(rst), .bus(bus0));
  wish_pack #(.DATA_WIDTH(8), .NUM_PACK(4), .TGC_WIDTH(2), .LITTLE_ENDIAN(1'b1))
    dut_le (.clk_i(clk), .rst_i(rst), .bus(bus1));

  int n_chk  = 0;
  int n_pass = 0;

  int          cyc = 0;
  int          stalls = 0;
  bit          phase_b2b = 1'b0;
  logic [31:0] q_dat[$];
  int          q_cyc[$];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (bus0.d_stb_o && bus0.d_ack_i) begin
      q_dat.push_back(bus0.d_dat_o);
      q_cyc.push_back(cyc);
    end
    if (phase_b2b && bus0.s_stb_i && bus0.s_cyc_i && !bus0.s_ack_o)
      stalls++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp)
      n_pass++;
    else
      $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic drive(input logic stb, input logic [7:0] dat, input logic [1:0] tgc);
    bus0.s_stb_i = stb; bus0.s_cyc_i = stb; bus0.s_dat_i = dat; bus0.s_tgc_i = tgc;
    bus1.s_stb_i = stb; bus1.s_cyc_i = stb; bus1.s_dat_i = dat; bus1.s_tgc_i = tgc;
  endtask

  task automatic set_ack(input logic a);
    bus0.d_ack_i = a;
    bus1.d_ack_i = a;
  endtask

  // Presents one beat and returns #1 after the edge that accepted it.
  task automatic send(input logic [7:0] dat, input logic [1:0] tgc);
    bit ok = 1'b0;
    drive(1'b1, dat, tgc);
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (bus0.s_ack_o) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
    end
    if (!ok) chk("send_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic idle();
    drive(1'b0, 8'h00, 2'b00);
  endtask

  initial begin
    rst = 1'b1;
    idle();
    set_ack(1'b1);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    chk("rst_stb", 32'(bus0.d_stb_o), 32'd0);
    chk("rst_dat", bus0.d_dat_o, 32'd0);
    chk("rst_cnt", 32'(bus0.d_cnt_o), 32'd0);
    chk("rst_tgc", 32'(bus0.d_tgc_o), 32'd0);
    chk("rst_ack", 32'(bus0.s_ack_o), 32'd0);

    // Full word, both endiannesses
    send(8'h11, 2'b01); send(8'h22, 2'b00); send(8'h33, 2'b00); send(8'h44, 2'b10);
    chk("full_stb", 32'(bus0.d_stb_o), 32'd1);
    chk("full_dat", bus0.d_dat_o, 32'h11223344);
    chk("full_cnt", 32'(bus0.d_cnt_o), 32'd4);
    chk("full_tgc", 32'(bus0.d_tgc_o), 32'd3);
    chk("le_dat", bus1.d_dat_o, 32'h44332211);
    chk("le_cnt", 32'(bus1.d_cnt_o), 32'd4);
    chk("le_tgc", 32'(bus1.d_tgc_o), 32'd3);
    idle();
    @(posedge clk); #1;
    chk("full_stb_clr", 32'(bus0.d_stb_o), 32'd0);

    // Partial word, then a full packet realigned at lane 0
    send(8'hAA, 2'b01); send(8'hBB, 2'b10);
    chk("part_dat", bus0.d_dat_o, 32'hAABB0000);
    chk("part_cnt", 32'(bus0.d_cnt_o), 32'd2);
    chk("part_tgc", 32'(bus0.d_tgc_o), 32'd3);
    chk("part_le_dat", bus1.d_dat_o, 32'h0000BBAA);
    send(8'h01, 2'b01); send(8'h02, 2'b00); send(8'h03, 2'b00); send(8'h04, 2'b10);
    chk("after_dat", bus0.d_dat_o, 32'h01020304);
    chk("after_cnt", 32'(bus0.d_cnt_o), 32'd4);
    idle();
    @(posedge clk); #1;

    // Backpressure
    set_ack(1'b0);
    send(8'h01, 2'b01); send(8'h02, 2'b00); send(8'h03, 2'b00); send(8'h04, 2'b00);
    send(8'h05, 2'b00); send(8'h06, 2'b00); send(8'h07, 2'b00);
    drive(1'b1, 8'h08, 2'b10);
    @(negedge clk);
    chk("bp_ack", 32'(bus0.s_ack_o), 32'd0);
    chk("bp_stall", 32'(bus0.s_stall_o), 32'd1);
    chk("bp_hold_stb", 32'(bus0.d_stb_o), 32'd1);
    chk("bp_hold_dat", bus0.d_dat_o, 32'h01020304);
    chk("bp_hold_tgc", 32'(bus0.d_tgc_o), 32'd1);
    repeat (3) @(negedge clk);
    chk("bp_hold_dat2", bus0.d_dat_o, 32'h01020304);
    set_ack(1'b1);
    #1;
    chk("bp_ack_same", 32'(bus0.s_ack_o), 32'd1);
    chk("bp_stall_clr", 32'(bus0.s_stall_o), 32'd0);
    @(posedge clk); #1;
    idle();
    chk("bp_next_stb", 32'(bus0.d_stb_o), 32'd1);
    chk("bp_next_dat", bus0.d_dat_o, 32'h05060708);
    chk("bp_next_tgc", 32'(bus0.d_tgc_o), 32'd2);
    chk("bp_next_cnt", 32'(bus0.d_cnt_o), 32'd4);
    @(posedge clk); #1;

    // Back-to-back, 16 beats
    q_dat.delete();
    q_cyc.delete();
    stalls = 0;
    phase_b2b = 1'b1;
    for (int i = 0; i < 16; i++)
      send(8'h10 + 8'(i), (i == 0) ? 2'b01 : (i == 15) ? 2'b10 : 2'b00);
    idle();
    phase_b2b = 1'b0;
    @(posedge clk); #1;
    chk("b2b_stalls", 32'(stalls), 32'd0);
    chk("b2b_words", 32'(q_dat.size()), 32'd4);
    if (q_dat.size() == 4) begin
      chk("b2b_w0", q_dat[0], 32'h10111213);
      chk("b2b_w1", q_dat[1], 32'h14151617);
      chk("b2b_w2", q_dat[2], 32'h18191A1B);
      chk("b2b_w3", q_dat[3], 32'h1C1D1E1F);
      for (int i = 1; i < 4; i++)
        chk("b2b_spacing", 32'(q_cyc[i] - q_cyc[0]), 32'(4 * i));
    end

    // Reset mid-word
    send(8'h11, 2'b01); send(8'h22, 2'b00);
    idle();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mr_stb", 32'(bus0.d_stb_o), 32'd0);
    chk("mr_dat", bus0.d_dat_o, 32'd0);
    chk("mr_cnt", 32'(bus0.d_cnt_o), 32'd0);
    chk("mr_tgc", 32'(bus0.d_tgc_o), 32'd0);
    send(8'h55, 2'b01); send(8'h66, 2'b00); send(8'h77, 2'b00); send(8'h88, 2'b10);
    chk("mr_dat2", bus0.d_dat_o, 32'h55667788);
    chk("mr_cnt2", 32'(bus0.d_cnt_o), 32'd4);
    chk("mr_tgc2", 32'(bus0.d_tgc_o), 32'd3);
    idle();
    @(posedge clk); #1;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
